// File: rtl/pg_input_arbiter_pkg.sv
// Shared types for the port_group input arbiter: match/metadata widths and FSM encoding.
package pg_input_arbiter_pkg;

   localparam int PG_MATCH_DW = 128;
   localparam int PG_EMPTY_W  = 6;

   typedef struct packed {
      logic [15:0] rule_id;
      logic [7:0]  port_grp;
      logic [7:0]  flags;
   } metadata_t;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

endpackage

// File: rtl/pg_input_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] gidx,
   output logic         any
);

   logic [W-1:0] idx;

   always_comb begin
      gnt  = '0;
      gidx = '0;
      any  = 1'b0;
      idx  = '0;
      for (int k = 0; k < N; k++) begin
         idx = W'((int'(ptr) + k) % N);
         if (!any && req[idx]) begin
            gnt[idx] = 1'b1;
            gidx     = idx;
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pg_input_arbiter.sv
// Shares one port_group input among NUM_REQ matcher lanes, one whole packet per grant.
//   state    | meaning
//   ARB_IDLE | no owner; round-robin pick among lanes presenting metadata
//   ARB_BUSY | lane gidx owns port_group until its eop beat and meta word both hand off
module pg_input_arbiter
   import pg_input_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int REQ_W   = $clog2(NUM_REQ)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              in_match_sop,
   input  logic [NUM_REQ-1:0]              in_match_eop,
   input  logic [NUM_REQ*PG_MATCH_DW-1:0]  in_match_data,
   input  logic [NUM_REQ*PG_EMPTY_W-1:0]   in_match_empty,
   input  logic [NUM_REQ-1:0]              in_match_valid,
   output logic [NUM_REQ-1:0]              in_match_ready,
   input  logic [NUM_REQ-1:0]              in_meta_valid,
   input  metadata_t [NUM_REQ-1:0]         in_meta_data,
   output logic [NUM_REQ-1:0]              in_meta_ready,
   output logic                            out_match_sop,
   output logic                            out_match_eop,
   output logic [PG_MATCH_DW-1:0]          out_match_data,
   output logic [PG_EMPTY_W-1:0]           out_match_empty,
   output logic                            out_match_valid,
   input  logic                            out_match_ready,
   output logic                            out_meta_valid,
   output metadata_t                       out_meta_data,
   input  logic                            out_meta_ready,
   output logic [NUM_REQ-1:0]              grant,
   output logic                            busy,
   output logic [31:0]                     pkt_cnt
);

   arb_state_t         state;
   logic [REQ_W-1:0]   gidx;
   logic [REQ_W-1:0]   rr_ptr;
   logic               match_done;
   logic               meta_done;
   logic [NUM_REQ-1:0] arb_gnt;
   logic [REQ_W-1:0]   arb_idx;
   logic               arb_any;
   logic               match_fire;
   logic               meta_fire;

   logic [PG_MATCH_DW-1:0] lane_data  [NUM_REQ];
   logic [PG_EMPTY_W-1:0]  lane_empty [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      assign lane_data[i]  = in_match_data[i*PG_MATCH_DW +: PG_MATCH_DW];
      assign lane_empty[i] = in_match_empty[i*PG_EMPTY_W +: PG_EMPTY_W];
   end

   rr_arbiter #(.N(NUM_REQ), .W(REQ_W)) u_rr (
      .req  (in_meta_valid),
      .ptr  (rr_ptr),
      .gnt  (arb_gnt),
      .gidx (arb_idx),
      .any  (arb_any)
   );

   // Readies are masked once a stream is done so the owner's next packet stays parked upstream.
   always_comb begin
      out_match_valid = busy & ~match_done & in_match_valid[gidx];
      out_match_sop   = busy & in_match_sop[gidx];
      out_match_eop   = busy & in_match_eop[gidx];
      out_match_data  = busy ? lane_data[gidx]  : '0;
      out_match_empty = busy ? lane_empty[gidx] : '0;
      out_meta_valid  = busy & ~meta_done & in_meta_valid[gidx];
      out_meta_data   = busy ? in_meta_data[gidx] : '0;
      in_match_ready  = '0;
      in_meta_ready   = '0;
      if (busy) begin
         in_match_ready[gidx] = out_match_ready & ~match_done;
         in_meta_ready[gidx]  = out_meta_ready & ~meta_done;
      end
   end

   assign match_fire = out_match_valid & out_match_ready & out_match_eop;
   assign meta_fire  = out_meta_valid & out_meta_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ARB_IDLE;
         grant      <= '0;
         busy       <= 1'b0;
         gidx       <= '0;
         rr_ptr     <= '0;
         match_done <= 1'b0;
         meta_done  <= 1'b0;
         pkt_cnt    <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (arb_any) begin
                  state <= ARB_BUSY;
                  grant <= arb_gnt;
                  gidx  <= arb_idx;
                  busy  <= 1'b1;
               end
            end
            ARB_BUSY: begin
               if ((match_done | match_fire) && (meta_done | meta_fire)) begin
                  state      <= ARB_IDLE;
                  grant      <= '0;
                  busy       <= 1'b0;
                  match_done <= 1'b0;
                  meta_done  <= 1'b0;
                  rr_ptr     <= (gidx == REQ_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
                  pkt_cnt    <= pkt_cnt + 32'd1;
               end else begin
                  if (match_fire) match_done <= 1'b1;
                  if (meta_fire)  meta_done  <= 1'b1;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pg_input_arbiter.sv
// Directed bench for pg_input_arbiter: queue-driven lane sources, handshake log, hand-computed expectations.
module tb_pg_input_arbiter;
   import pg_input_arbiter_pkg::*;

   localparam int N = 4;

   typedef logic [128:0] cv_t;
   typedef struct packed {
      logic         sop;
      logic         eop;
      logic [127:0] data;
      logic [5:0]   empty;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     in_match_sop, in_match_eop, in_match_valid, in_match_ready;
   logic [N*128-1:0] in_match_data;
   logic [N*6-1:0]   in_match_empty;
   logic [N-1:0]     in_meta_valid, in_meta_ready;
   metadata_t [N-1:0] in_meta_data;
   logic             out_match_sop, out_match_eop, out_match_valid, out_match_ready;
   logic [127:0]     out_match_data;
   logic [5:0]       out_match_empty;
   logic             out_meta_valid, out_meta_ready;
   metadata_t        out_meta_data;
   logic [N-1:0]     grant;
   logic             busy;
   logic [31:0]      pkt_cnt;

   int n_vec = 0;
   int n_err = 0;

   beat_t     bq [N][$];
   metadata_t mq [N][$];
   cv_t       obs_m [$];
   metadata_t obs_t [$];
   logic [N-1:0] obs_g [$];
   int        viol;
   logic      busy_q = 1'b0;
   logic [N-1:0] take_b, take_m;

   pg_input_arbiter #(.NUM_REQ(N), .REQ_W(2)) dut (
      .clk(clk), .rst(rst),
      .in_match_sop(in_match_sop), .in_match_eop(in_match_eop),
      .in_match_data(in_match_data), .in_match_empty(in_match_empty),
      .in_match_valid(in_match_valid), .in_match_ready(in_match_ready),
      .in_meta_valid(in_meta_valid), .in_meta_data(in_meta_data),
      .in_meta_ready(in_meta_ready),
      .out_match_sop(out_match_sop), .out_match_eop(out_match_eop),
      .out_match_data(out_match_data), .out_match_empty(out_match_empty),
      .out_match_valid(out_match_valid), .out_match_ready(out_match_ready),
      .out_meta_valid(out_meta_valid), .out_meta_data(out_meta_data),
      .out_meta_ready(out_meta_ready),
      .grant(grant), .busy(busy), .pkt_cnt(pkt_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input cv_t obs, input cv_t exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] dval(input int l, input int p, input int b);
      return {104'h0, 8'(l), 8'(p), 8'(b)};
   endfunction

   function automatic metadata_t mval(input int l, input int p);
      metadata_t m;
      m.rule_id  = 16'(16'hA000 + l*16 + p);
      m.port_grp = 8'(l);
      m.flags    = 8'(p);
      return m;
   endfunction

   task automatic push_pkt(input int l, input int p, input int nb, input bit with_meta);
      beat_t bt;
      for (int b = 0; b < nb; b++) begin
         bt.sop   = (b == 0);
         bt.eop   = (b == nb-1);
         bt.data  = dval(l, p, b);
         bt.empty = 6'(b);
         bq[l].push_back(bt);
      end
      if (with_meta) mq[l].push_back(mval(l, p));
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (bq[i].size() != 0) begin
            in_match_valid[i]            = 1'b1;
            in_match_sop[i]              = bq[i][0].sop;
            in_match_eop[i]              = bq[i][0].eop;
            in_match_data[i*128 +: 128]  = bq[i][0].data;
            in_match_empty[i*6 +: 6]     = bq[i][0].empty;
         end else begin
            in_match_valid[i]            = 1'b0;
            in_match_sop[i]              = 1'b0;
            in_match_eop[i]              = 1'b0;
            in_match_data[i*128 +: 128]  = '0;
            in_match_empty[i*6 +: 6]     = '0;
         end
         if (mq[i].size() != 0) begin
            in_meta_valid[i] = 1'b1;
            in_meta_data[i]  = mq[i][0];
         end else begin
            in_meta_valid[i] = 1'b0;
            in_meta_data[i]  = '0;
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_logs();
      obs_m.delete();
      obs_t.delete();
      obs_g.delete();
      viol = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         bq[i].delete();
         mq[i].delete();
      end
      drive();
      out_match_ready = 1'b1;
      out_meta_ready  = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic wait_pkts(input logic [31:0] target, input int budget);
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (pkt_cnt == target) break;
      end
      chk("wait_pkt_cnt", cv_t'(pkt_cnt), cv_t'(target));
   endtask

   // Lane sources and output monitor: sample handshakes mid-cycle, advance queues after the edge.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            take_b[i] = in_match_valid[i] & in_match_ready[i];
            take_m[i] = in_meta_valid[i] & in_meta_ready[i];
            if ((in_match_ready[i] | in_meta_ready[i]) & ~grant[i]) viol++;
         end
         if (out_match_valid & out_match_ready) obs_m.push_back({out_match_eop, out_match_data});
         if (out_meta_valid & out_meta_ready) obs_t.push_back(out_meta_data);
         if (busy & ~busy_q) obs_g.push_back(grant);
         busy_q = busy;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (take_b[i] && bq[i].size() != 0) void'(bq[i].pop_front());
            if (take_m[i] && mq[i].size() != 0) void'(mq[i].pop_front());
         end
         drive();
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      out_match_ready = 1'b0;
      out_meta_ready  = 1'b0;
      viol = 0;
      drive();
      do_reset();

      // reset state and single-lane packet
      @(negedge clk);
      chk("rst_grant", cv_t'(grant), cv_t'(0));
      chk("rst_busy", cv_t'(busy), cv_t'(0));
      chk("rst_pkt_cnt", cv_t'(pkt_cnt), cv_t'(0));
      chk("rst_match_valid", cv_t'(out_match_valid), cv_t'(0));
      chk("rst_meta_valid", cv_t'(out_meta_valid), cv_t'(0));
      chk("rst_match_ready", cv_t'(in_match_ready), cv_t'(0));
      chk("rst_meta_ready", cv_t'(in_meta_ready), cv_t'(0));
      cyc();
      push_pkt(0, 0, 3, 1);
      drive();
      @(negedge clk);
      chk("t1_grant_latency", cv_t'(grant), cv_t'(0));
      cyc();
      @(negedge clk);
      chk("t1_grant", cv_t'(grant), cv_t'(4'b0001));
      chk("t1_busy", cv_t'(busy), cv_t'(1));
      chk("t1_first_data", cv_t'(out_match_data), cv_t'(dval(0, 0, 0)));
      chk("t1_meta_data", cv_t'(out_meta_data), cv_t'(mval(0, 0)));
      wait_pkts(1, 20);
      chk("t1_idle", cv_t'(busy), cv_t'(0));
      chk("t1_beats", cv_t'(obs_m.size()), cv_t'(3));
      for (int b = 0; b < 3; b++)
         if (b < obs_m.size()) chk("t1_beat", obs_m[b], {(b == 2), dval(0, 0, b)});
      chk("t1_metas", cv_t'(obs_t.size()), cv_t'(1));
      cyc();
      push_pkt(0, 1, 1, 1);
      push_pkt(2, 0, 1, 1);
      drive();
      cyc();
      @(negedge clk);
      chk("t1_rr_ptr_skip", cv_t'(grant), cv_t'(4'b0100));

      // all lanes contending, 1-beat packets
      do_reset();
      for (int p = 0; p < 2; p++)
         for (int l = 0; l < N; l++) push_pkt(l, p, 1, 1);
      drive();
      wait_pkts(8, 100);
      chk("t2_grants", cv_t'(obs_g.size()), cv_t'(8));
      for (int k = 0; k < 8; k++)
         if (k < obs_g.size()) chk("t2_grant_order", cv_t'(obs_g[k]), cv_t'(4'b0001 << (k % 4)));
      chk("t2_beats", cv_t'(obs_m.size()), cv_t'(8));
      for (int k = 0; k < 8; k++)
         if (k < obs_m.size()) chk("t2_beat", obs_m[k], {1'b1, dval(k % 4, k / 4, 0)});
      chk("t2_metas", cv_t'(obs_t.size()), cv_t'(8));
      chk("t2_ready_leak", cv_t'(viol), cv_t'(0));

      // meta handshake before eop; lane keeps offering a second meta word
      do_reset();
      out_match_ready = 1'b0;
      push_pkt(3, 0, 2, 1);
      mq[3].push_back(mval(3, 1));
      drive();
      cyc();
      cyc();
      @(negedge clk);
      chk("t3a_busy", cv_t'(busy), cv_t'(1));
      chk("t3a_meta_masked", cv_t'(out_meta_valid), cv_t'(0));
      chk("t3a_meta_ready_masked", cv_t'(in_meta_ready), cv_t'(0));
      cyc();
      out_match_ready = 1'b1;
      wait_pkts(1, 20);
      chk("t3a_metas", cv_t'(obs_t.size()), cv_t'(1));
      chk("t3a_beats", cv_t'(obs_m.size()), cv_t'(2));

      // eop before meta handshake
      do_reset();
      out_meta_ready = 1'b0;
      push_pkt(0, 0, 1, 1);
      drive();
      cyc();
      cyc();
      @(negedge clk);
      chk("t3b_hold_busy", cv_t'(busy), cv_t'(1));
      chk("t3b_hold_cnt", cv_t'(pkt_cnt), cv_t'(0));
      chk("t3b_beats", cv_t'(obs_m.size()), cv_t'(1));
      cyc();
      out_meta_ready = 1'b1;
      wait_pkts(1, 10);
      chk("t3b_metas", cv_t'(obs_t.size()), cv_t'(1));
      chk("t3b_idle", cv_t'(busy), cv_t'(0));

      // backpressure toggling every cycle on a 5-beat packet
      do_reset();
      push_pkt(1, 0, 5, 1);
      drive();
      for (int k = 0; k < 60 && pkt_cnt != 1; k++) begin
         cyc();
         out_match_ready = ~out_match_ready;
         @(negedge clk);
         if (busy && bq[1].size() != 0)
            chk("t4_ready_mirror", cv_t'(in_match_ready), cv_t'({2'b00, out_match_ready, 1'b0}));
      end
      chk("t4_pkt_cnt", cv_t'(pkt_cnt), cv_t'(1));
      chk("t4_beats", cv_t'(obs_m.size()), cv_t'(5));
      for (int b = 0; b < 5; b++)
         if (b < obs_m.size()) chk("t4_beat", obs_m[b], {(b == 4), dval(1, 0, b)});

      // next packet's beats held back after eop while grant is still held
      do_reset();
      out_meta_ready = 1'b0;
      push_pkt(2, 0, 1, 1);
      push_pkt(2, 1, 1, 0);
      drive();
      cyc();
      cyc();
      @(negedge clk);
      chk("t5_valid_masked", cv_t'(out_match_valid), cv_t'(0));
      chk("t5_ready_masked", cv_t'(in_match_ready), cv_t'(0));
      chk("t5_busy", cv_t'(busy), cv_t'(1));
      chk("t5_beats_held", cv_t'(obs_m.size()), cv_t'(1));
      cyc();
      out_meta_ready = 1'b1;
      wait_pkts(1, 10);
      cyc();
      mq[2].push_back(mval(2, 1));
      drive();
      wait_pkts(2, 20);
      chk("t5_beats", cv_t'(obs_m.size()), cv_t'(2));
      if (obs_m.size() > 1) chk("t5_second_beat", obs_m[1], {1'b1, dval(2, 1, 0)});
      chk("t5_grants", cv_t'(obs_g.size()), cv_t'(2));

      // reset mid-packet (pkt_cnt is 2 here; rr_ptr=3 so lane 1 wins via wrap)
      cyc();
      push_pkt(1, 0, 4, 1);
      drive();
      cyc();
      @(negedge clk);
      chk("t6_grant", cv_t'(grant), cv_t'(4'b0010));
      cyc();
      rst = 1'b1;
      cyc();
      @(negedge clk);
      chk("t6_grant_drop", cv_t'(grant), cv_t'(0));
      chk("t6_busy", cv_t'(busy), cv_t'(0));
      chk("t6_pkt_cnt", cv_t'(pkt_cnt), cv_t'(0));
      chk("t6_match_valid", cv_t'(out_match_valid), cv_t'(0));
      chk("t6_meta_valid", cv_t'(out_meta_valid), cv_t'(0));
      chk("t6_match_ready", cv_t'(in_match_ready), cv_t'(0));
      chk("t6_meta_ready", cv_t'(in_meta_ready), cv_t'(0));
      do_reset();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
